// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its write-port arbiter.
package regfile_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef enum logic {
    A_PRI   = 1'b0,
    B_FORCE = 1'b1
  } arb_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port arbiter: source A has fixed priority, source B is protected by a
// starvation counter. The register file write port is driven from registers.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int DW         = regfile_pkg::DW,
  parameter int AW         = regfile_pkg::AW,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  output logic          b_forced
);

  localparam logic [3:0] WAIT_LAST = 4'(STARVE_MAX - 1);

  arb_state_t    r_state;
  arb_state_t    w_state_next;
  logic [3:0]    r_wait_cnt;
  logic [3:0]    w_wait_cnt_next;
  logic          r_we3;
  logic [AW-1:0] r_wa3;
  logic [DW-1:0] r_wd3;

  logic          w_a_ready;
  logic          w_b_ready;
  logic          w_a_xfer;
  logic          w_b_xfer;
  logic          w_xfer;
  logic [AW-1:0] w_win_addr;
  logic [DW-1:0] w_win_data;

  // Each ready depends only on state and the other source's valid.
  always_comb begin
    w_a_ready    = 1'b1;
    w_b_ready    = 1'b0;
    w_state_next = r_state;
    case (r_state)
      A_PRI: begin
        w_a_ready = 1'b1;
        w_b_ready = !a_valid;
        if (b_valid && !w_b_ready && (r_wait_cnt == WAIT_LAST))
          w_state_next = B_FORCE;
      end
      B_FORCE: begin
        w_b_ready = 1'b1;
        w_a_ready = !b_valid;
        if (w_b_xfer || !b_valid)
          w_state_next = A_PRI;
      end
      default: w_state_next = A_PRI;
    endcase
  end

  assign w_a_xfer   = a_valid && w_a_ready;
  assign w_b_xfer   = b_valid && w_b_ready;
  assign w_xfer     = w_a_xfer || w_b_xfer;
  assign w_win_addr = w_a_xfer ? a_addr : b_addr;
  assign w_win_data = w_a_xfer ? a_data : b_data;

  always_comb begin
    w_wait_cnt_next = r_wait_cnt;
    if (!b_valid || w_b_xfer)
      w_wait_cnt_next = 4'd0;
    else if (r_wait_cnt != WAIT_LAST)
      w_wait_cnt_next = r_wait_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= A_PRI;
      r_wait_cnt <= 4'd0;
      r_we3      <= 1'b0;
      r_wa3      <= '0;
      r_wd3      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      // A write to r0 still completes its handshake but never enables the port.
      r_we3      <= w_xfer && (w_win_addr != AW'(REG_ZERO));
      if (w_xfer) begin
        r_wa3 <= w_win_addr;
        r_wd3 <= w_win_data;
      end
    end
  end

  assign a_ready  = w_a_ready;
  assign b_ready  = w_b_ready;
  assign we3      = r_we3;
  assign wa3      = r_wa3;
  assign wd3      = r_wd3;
  assign b_forced = (r_state == B_FORCE);

endmodule

// File: doc/regfile_wr_arb.md
# regfile_wr_arb

Write-port arbiter for the 32x32 pipeline register file. Two writeback sources share the register file's single write port (`we3`/`wa3`/`wd3`): source A is the main pipeline writeback and source B is the long-latency unit writeback (multiply/divide, load miss). The arbiter gives A fixed priority and protects B with a starvation counter. It drives the write port from registers, so the write port sees one cycle of latency after each handshake. It sits between the writeback stage and `regfile`.

## Interface
Parameters:
- `DW`, 32, data width
- `AW`, 5, register address width
- `STARVE_MAX`, 4, consecutive cycles B may wait while valid before it is forced; legal range 1..15

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `a_valid`  in  1  source A write request
- `a_ready`  out  1  source A accepted this cycle
- `a_addr`  in  AW  source A destination register
- `a_data`  in  DW  source A write data
- `b_valid`  in  1  source B write request
- `b_ready`  out  1  source B accepted this cycle
- `b_addr`  in  AW  source B destination register
- `b_data`  in  DW  source B write data
- `we3`  out  1  register file write enable (registered)
- `wa3`  out  AW  register file write address (registered)
- `wd3`  out  DW  register file write data (registered)
- `b_forced`  out  1  high while the FSM is in B_FORCE (debug/perf)

## Operation
- **Handshake:** a transfer occurs on a rising edge with `x_valid && x_ready`. At most one source transfers per cycle.
- **Source stability:** a source must hold `valid`, `addr` and `data` stable until its transfer.
- **FSM, two states, reset state A_PRI:**
  - A_PRI: `a_ready = 1`; `b_ready = !a_valid`.
  - B_FORCE: `b_ready = 1`; `a_ready = !b_valid`.
  - A_PRI → B_FORCE when `b_valid && !b_ready && wait_cnt == STARVE_MAX-1`.
  - B_FORCE → A_PRI on a B transfer, or when `b_valid` is low.
- **Starvation counter:** `wait_cnt` is 4 bits.
  - Increments each cycle with `b_valid && !b_ready`.
  - Clears to 0 on a B transfer or when `b_valid` is low.
  - Saturates at STARVE_MAX-1.
- **Write-port register:** on a transfer, `wa3`/`wd3` load the winner's addr/data. `we3` loads 1, except when the winner's addr is 0, where `we3` loads 0: the transfer completes but r0 is never written. With no transfer, `we3` loads 0 and `wa3`/`wd3` hold.
- **Same-address writes:** commit in transfer order, so the later transfer wins in the register file.
- **Ready timing:** `a_ready`/`b_ready` are combinational from state and the opposing valid. There is no combinational path from `x_valid` to the same source's ready.

## Timing
- Reset values (`rst` low, asynchronous): `we3 = 0`, `wa3 = 0`, `wd3 = 0`, `b_forced = 0`, state A_PRI, `wait_cnt = 0`.
- Reset mid-operation: any request not yet transferred is dropped. A write already registered but not yet consumed is cancelled, because `we3` clears immediately.
- Latency: a transfer on edge N gives `we3`/`wa3`/`wd3` valid during cycle N → N+1, and the register file commits on edge N+1.
- Throughput: 1 write per cycle.
- Worst-case B wait with A continuously valid: STARVE_MAX cycles. B transfers on the (STARVE_MAX+1)-th edge after it asserts valid.
- In B_FORCE with A continuously valid: A stalls exactly one cycle per forced B transfer.
- Both sources idle: the FSM holds its state (B_FORCE exits because `b_valid` is low), and `we3` stays 0.

## Structure
- Shared package `regfile_pkg`:
  - `DW`/`AW` defaults
  - state encoding `arb_state_t` {A_PRI, B_FORCE}
  - `REG_ZERO = 5'd0`
- Single flat module. No sub-module is natural; the FSM, counter and output register together are about 150 lines.

## Test plan
- **Reset:** `rst` low with `a_valid = b_valid = 1` → `we3 = 0`, `wa3 = 0`, `wd3 = 0`, `b_forced = 0`, and no ready transfer is recorded. Release `rst` → A transfers on the first edge.
- **Single A write:** A writes addr 8, data 0x6 → one cycle later `we3 = 1`, `wa3 = 8`, `wd3 = 0x6`. A back-to-back write to addr 9, data 0x3 follows on the next cycle.
- **Starvation with STARVE_MAX = 4:** A continuously valid, B valid with addr 9, data 0xAB → B transfers on the 5th edge and `b_forced = 1` for that cycle. The written sequence is A, A, A, A, B; then A resumes.
- **Collision:** A and B simultaneously target addr 3 (A = 0x11, B = 0x22) in A_PRI → A commits first, then B. The final register file value at addr 3 is 0x22.
- **Zero register:** B writes addr 0, data 0xFFFF_FFFF → the handshake completes (`b_ready = 1`) and `we3` stays 0.
- **Async reset mid-operation:** assert `rst` low in B_FORCE, mid-cycle, with `we3 = 1` → `we3 = 0`, `b_forced = 0` and `wait_cnt = 0` immediately, without waiting for a clock edge.
